// File: rtl/fsm_cfg_loader.sv
// -----------------------------------------------------------------------------
// fsm_cfg_loader
//
// Configuration sequencer for the programmable-jump FSM datapath. On an
// accepted start it captures {cfg_out_sel, cfg_clk_sel, cfg_state} into a
// shadow register and shifts the frame MSB-first into the downstream SIPO. The
// FSM is held in reset (fsm_hold) until loading completes. If
// FSM_CFG_VERIFY_EN is defined, the frame is then read back through the PISO
// chain, followed by a fixed 5'b01010 tail, and compared before release.
//
// Build option: FSM_CFG_VERIFY_EN (undefined by default)
//   defined   - VERIFY state, rb_shift, comparator and verify flags are built
//   undefined - SETTLE goes directly to RUN; rb_shift/verify_ok/verify_err
//               are tied to 0 and rb_data is ignored
//
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   start        load request, honoured only in IDLE or RUN
//   cfg_state    jump table, entry 1 in the MSBs
//   cfg_clk_sel  clock-select bit to load
//   cfg_out_sel  output-select bit to load
//   busy         high in LOAD, SETTLE, VERIFY
//   done         one-cycle pulse on entry to RUN
//   fsm_hold     keeps the FSM in reset (high everywhere except RUN)
//   ser_data     serial configuration bit
//   ser_shift    one-cycle strobe, downstream samples ser_data on it
//   rb_data      serial readback bit
//   rb_shift     one-cycle readback strobe
//   verify_ok    readback matched, sticky until the next start
//   verify_err   readback mismatched, sticky until the next start
// -----------------------------------------------------------------------------
module fsm_cfg_loader #(
  parameter int N_STATES = 5,
  parameter int STATE_W  = 5,
  parameter int DIV      = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [N_STATES*STATE_W-1:0] cfg_state,
  input  logic                        cfg_clk_sel,
  input  logic                        cfg_out_sel,
  output logic                        busy,
  output logic                        done,
  output logic                        fsm_hold,
  output logic                        ser_data,
  output logic                        ser_shift,
  input  logic                        rb_data,
  output logic                        rb_shift,
  output logic                        verify_ok,
  output logic                        verify_err
);

  localparam int F     = 2 + N_STATES * STATE_W;  // frame length
  localparam int R     = F + 5;                    // readback length
  localparam int CNT_W = $clog2(R + 1);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(F - 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_VERIFY,
    S_RUN
  } state_t;

  state_t           state, state_nxt;
  logic [F-1:0]     cfg_sr;    // shadow frame, rotated while it is sent
  logic [F-1:0]     cfg_rot;
  logic [CNT_W-1:0] bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             start_ok;
  logic             last_tx;
  logic             done_q;

  assign tick     = (div_cnt == DIV_MAX);
  assign start_ok = start && ((state == S_IDLE) || (state == S_RUN));
  assign last_tx  = (bit_cnt == LAST_TX);
  // Rotating instead of shifting leaves the shadow intact after F strobes,
  // so the same register supplies the expected readback stream.
  assign cfg_rot  = {cfg_sr[F-2:0], cfg_sr[F-1]};

`ifdef FSM_CFG_VERIFY_EN
  localparam logic [CNT_W-1:0] LAST_RB = CNT_W'(R - 1);
  localparam logic [4:0]       RB_TAIL = 5'b01010;

  logic [4:0] tail_sr;
  logic       in_frame;
  logic       exp_bit;
  logic       last_rb;
  logic       rb_bad;
  logic       ok_q, err_q;

  assign in_frame = (bit_cnt < CNT_W'(F));
  assign exp_bit  = in_frame ? cfg_sr[F-1] : tail_sr[4];
  assign last_rb  = (bit_cnt == LAST_RB);
  assign rb_bad   = rb_shift && (rb_data != exp_bit);

  always_ff @(posedge clk) begin
    if (rst) begin
      tail_sr <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (start_ok) begin
      tail_sr <= RB_TAIL;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (rb_shift) begin
      if (!in_frame) tail_sr <= {tail_sr[3:0], 1'b0};
      if (rb_bad)       err_q <= 1'b1;
      else if (last_rb) ok_q  <= 1'b1;
    end
  end
`else
  logic unused_rb_data;
  assign unused_rb_data = rb_data;
`endif

  // State register.
  // NOTE: every clocked process uses non-blocking assignments so all flops
  // update together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: the default at the top of the block keeps every path assigned, so
  // no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_RUN: if (start) state_nxt = S_LOAD;
      S_LOAD:        if (tick && last_tx) state_nxt = S_SETTLE;
      S_SETTLE: begin
`ifdef FSM_CFG_VERIFY_EN
        state_nxt = S_VERIFY;
`else
        state_nxt = S_RUN;
`endif
      end
`ifdef FSM_CFG_VERIFY_EN
      S_VERIFY: begin
        if (rb_bad)                   state_nxt = S_IDLE;
        else if (rb_shift && last_rb) state_nxt = S_RUN;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: shadow frame, bit counter and divider. SETTLE holds both
  // counters, which are already 0 after the final LOAD strobe, so the
  // readback divider starts fresh.
  // NOTE: the shadow is cleared on reset so an aborted load leaves nothing
  // stale behind; it is a plain register, not a RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_sr  <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_nxt == S_RUN) && (state != S_RUN);
      case (state)
        S_IDLE, S_RUN: begin
          if (start) begin
            cfg_sr  <= {cfg_out_sel, cfg_clk_sel, cfg_state};
            bit_cnt <= '0;
            div_cnt <= '0;
          end
        end
        S_LOAD: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick) begin
            cfg_sr  <= cfg_rot;
            bit_cnt <= last_tx ? '0 : bit_cnt + 1'b1;
          end
        end
`ifdef FSM_CFG_VERIFY_EN
        S_VERIFY: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (in_frame) cfg_sr <= cfg_rot;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    busy      = (state == S_LOAD) || (state == S_SETTLE) || (state == S_VERIFY);
    fsm_hold  = (state != S_RUN);
    done      = done_q;
    ser_shift = (state == S_LOAD) && tick;
    ser_data  = (state == S_LOAD) && cfg_sr[F-1];
`ifdef FSM_CFG_VERIFY_EN
    rb_shift   = (state == S_VERIFY) && tick;
    verify_ok  = ok_q;
    verify_err = err_q;
`else
    rb_shift   = 1'b0;
    verify_ok  = 1'b0;
    verify_err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_fsm_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_fsm_cfg_loader
//
// Directed bench for fsm_cfg_loader. Two instances share the configuration
// inputs: u_d1 with DIV=1 and u_d3 with DIV=3. Each has a small model of the
// downstream chain: a SIPO that captures ser_data on ser_shift, and a PISO
// that returns {captured frame, 5'b01010} on rb_shift. The PISO can flip one
// readback bit. Expected cycle numbers count from the edge where start is
// sampled (edge 0, so cycle 1 follows it).
// -----------------------------------------------------------------------------
module tb_fsm_cfg_loader;

  localparam int F = 27;
  localparam int R = 32;

`ifdef FSM_CFG_VERIFY_EN
  localparam int DONE1 = 61;
  localparam int DONE3 = 179;
  localparam int NRB   = 32;
  localparam int VEN   = 1;
`else
  localparam int DONE1 = 29;
  localparam int DONE3 = 83;
  localparam int NRB   = 0;
  localparam int VEN   = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start3;
  logic [24:0] cfg_state;
  logic        cfg_clk_sel, cfg_out_sel;

  logic busy1, done1, hold1, sd1, ss1, rbd1, rbs1, vok1, verr1;
  logic busy3, done3, hold3, sd3, ss3, rbd3, rbs3, vok3, verr3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fsm_cfg_loader #(.N_STATES(5), .STATE_W(5), .DIV(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start1), .cfg_state(cfg_state),
    .cfg_clk_sel(cfg_clk_sel), .cfg_out_sel(cfg_out_sel),
    .busy(busy1), .done(done1), .fsm_hold(hold1), .ser_data(sd1),
    .ser_shift(ss1), .rb_data(rbd1), .rb_shift(rbs1),
    .verify_ok(vok1), .verify_err(verr1)
  );

  fsm_cfg_loader #(.N_STATES(5), .STATE_W(5), .DIV(3)) u_d3 (
    .clk(clk), .rst(rst), .start(start3), .cfg_state(cfg_state),
    .cfg_clk_sel(cfg_clk_sel), .cfg_out_sel(cfg_out_sel),
    .busy(busy3), .done(done3), .fsm_hold(hold3), .ser_data(sd3),
    .ser_shift(ss3), .rb_data(rbd3), .rb_shift(rbs3),
    .verify_ok(vok3), .verify_err(verr3)
  );

  // Downstream chain models.
  logic [F-1:0] sipo1 = '0, sipo3 = '0;
  logic [R-1:0] pis1  = '0, pis3  = '0;
  int           rbc1  = 0,  rbc3  = 0;
  int           flip1 = -1, flip3 = -1;

  always_ff @(posedge clk) begin
    if (ss1) begin
      sipo1 <= {sipo1[F-2:0], sd1};
      pis1  <= {sipo1[F-2:0], sd1, 5'b01010};
      rbc1  <= 0;
    end else if (rbs1) begin
      pis1 <= {pis1[R-2:0], 1'b0};
      rbc1 <= rbc1 + 1;
    end
  end

  always_ff @(posedge clk) begin
    if (ss3) begin
      sipo3 <= {sipo3[F-2:0], sd3};
      pis3  <= {sipo3[F-2:0], sd3, 5'b01010};
      rbc3  <= 0;
    end else if (rbs3) begin
      pis3 <= {pis3[R-2:0], 1'b0};
      rbc3 <= rbc3 + 1;
    end
  end

  assign rbd1 = pis1[R-1] ^ (rbc1 == flip1);
  assign rbd3 = pis3[R-1] ^ (rbc3 == flip3);

  // Observation results.
  int   n_ss, first_ss, last_ss, sd_bad, unstable;
  int   n_done, done_cyc, n_rbs, first_rbs;
  logic hold_at_done, vok_at_done;
  logic hold_c1, busy_c1, vok_c1, verr_c1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watches one instance for ncyc cycles starting in cycle 1. If inj_cyc
  // is in range, start is raised for that single cycle.
  task automatic observe(input bit d3, input int ncyc, input int inj_cyc,
                         input logic [F-1:0] exp_frame);
    logic [F-1:0] fr;
    logic         prev_sd, prev_ss;
    fr = exp_frame;
    prev_sd = 1'b0;
    prev_ss = 1'b0;
    n_ss = 0; first_ss = 0; last_ss = 0; sd_bad = 0; unstable = 0;
    n_done = 0; done_cyc = 0; n_rbs = 0; first_rbs = 0;
    hold_at_done = 1'bx; vok_at_done = 1'bx;
    for (int c = 1; c <= ncyc; c++) begin
      logic ss, sd, dn, rbs, hold, bsy, vok, verr;
      ss   = d3 ? ss3   : ss1;
      sd   = d3 ? sd3   : sd1;
      dn   = d3 ? done3 : done1;
      rbs  = d3 ? rbs3  : rbs1;
      hold = d3 ? hold3 : hold1;
      bsy  = d3 ? busy3 : busy1;
      vok  = d3 ? vok3  : vok1;
      verr = d3 ? verr3 : verr1;
      if (c == 1) begin
        hold_c1 = hold; busy_c1 = bsy; vok_c1 = vok; verr_c1 = verr;
      end
      if (ss) begin
        n_ss++;
        if (n_ss == 1) first_ss = c;
        last_ss = c;
        if (sd !== fr[F-1]) sd_bad++;
        fr = {fr[F-2:0], 1'b0};
      end
      if (c > 1 && sd !== prev_sd && !prev_ss) unstable++;
      if (dn) begin
        n_done++;
        done_cyc = c;
        hold_at_done = hold;
        vok_at_done = vok;
      end
      if (rbs) begin
        n_rbs++;
        if (n_rbs == 1) first_rbs = c;
      end
      prev_sd = sd;
      prev_ss = ss;
      if (d3) start3 = (c == inj_cyc);
      else    start1 = (c == inj_cyc);
      tick();
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    cfg_state = '0;
    cfg_clk_sel = 1'b0;
    cfg_out_sel = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state and quiet idle period.
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (ss1 || ss3 || rbs1 || rbs3) n++;
      tick();
    end
    check("idle_strobes", n, 0);
    check("rst_outs_d1", 32'({busy1, done1, hold1, sd1, ss1, rbs1, vok1, verr1}), 32'h20);
    check("rst_outs_d3", 32'({busy3, done3, hold3, sd3, ss3, rbs3, vok3, verr3}), 32'h20);

    // DIV=1 load of the alternating pattern.
    cfg_out_sel = 1'b1;
    cfg_clk_sel = 1'b0;
    cfg_state   = 25'h1555555;
    start1 = 1'b1;
    tick();
    observe(1'b0, 70, -1, 27'h5555555);
    check("a_busy_c1", 32'(busy_c1), 1);
    check("a_hold_c1", 32'(hold_c1), 1);
    check("a_n_strobes", n_ss, 27);
    check("a_first_strobe", first_ss, 1);
    check("a_last_strobe", last_ss, 27);
    check("a_ser_bits_bad", sd_bad, 0);
    check("a_sipo", 32'(sipo1), 32'h5555555);
    check("a_n_done", n_done, 1);
    check("a_done_cycle", done_cyc, DONE1);
    check("a_hold_at_done", 32'(hold_at_done), 0);
    check("a_vok_at_done", 32'(vok_at_done), VEN);
    check("a_n_rb", n_rbs, NRB);
`ifdef FSM_CFG_VERIFY_EN
    check("a_first_rb", first_rbs, 29);
`endif
    check("a_run_outs", 32'({busy1, hold1}), 0);

    // Reload from RUN; inputs change after capture and start is pulsed
    // again in LOAD, neither of which may disturb this load.
    check("b_hold_pre", 32'(hold1), 0);
    cfg_out_sel = 1'b0;
    cfg_clk_sel = 1'b1;
    cfg_state   = 25'h0ABCDEF;
    start1 = 1'b1;
    tick();
    cfg_out_sel = 1'b1;
    cfg_clk_sel = 1'b1;
    cfg_state   = '0;
    observe(1'b0, 70, 5, 27'h2ABCDEF);
    check("b_hold_c1", 32'(hold_c1), 1);
    check("b_busy_c1", 32'(busy_c1), 1);
    check("b_vok_cleared", 32'(vok_c1), 0);
    check("b_n_strobes", n_ss, 27);
    check("b_ser_bits_bad", sd_bad, 0);
    check("b_sipo", 32'(sipo1), 32'h2ABCDEF);
    check("b_done_cycle", done_cyc, DONE1);
    check("b_vok_at_done", 32'(vok_at_done), VEN);

`ifdef FSM_CFG_VERIFY_EN
    // Corrupt readback bit 10: error flag, no done, back to IDLE in hold.
    cfg_out_sel = 1'b1;
    cfg_clk_sel = 1'b0;
    cfg_state   = 25'h1555555;
    flip1 = 10;
    start1 = 1'b1;
    tick();
    observe(1'b0, 70, -1, 27'h5555555);
    flip1 = -1;
    check("c_n_done", n_done, 0);
    check("c_n_rb", n_rbs, 11);
    check("c_verr", 32'(verr1), 1);
    check("c_vok", 32'(vok1), 0);
    check("c_idle_outs", 32'({busy1, hold1}), 32'h1);
`endif

    // Reset at the 12th strobe aborts the load.
    cfg_out_sel = 1'b1;
    cfg_clk_sel = 1'b0;
    cfg_state   = 25'h1555555;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (11) tick();
    check("d_strobe12", 32'(ss1), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("d_abort_outs", 32'({busy1, hold1, ss1, verr1}), 32'h4);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (ss1) n++;
      tick();
    end
    check("d_no_strobes", n, 0);
    start1 = 1'b1;
    tick();
    observe(1'b0, 70, -1, 27'h5555555);
    check("d_n_strobes", n_ss, 27);
    check("d_sipo", 32'(sipo1), 32'h5555555);
    check("d_done_cycle", done_cyc, DONE1);

    // DIV=3: a strobe every third cycle, ser_data stable in between.
    start3 = 1'b1;
    tick();
    observe(1'b1, 200, -1, 27'h5555555);
    check("e_n_strobes", n_ss, 27);
    check("e_first_strobe", first_ss, 3);
    check("e_last_strobe", last_ss, 81);
    check("e_unstable", unstable, 0);
    check("e_ser_bits_bad", sd_bad, 0);
    check("e_sipo", 32'(sipo3), 32'h5555555);
    check("e_done_cycle", done_cyc, DONE3);
    check("e_hold_at_done", 32'(hold_at_done), 0);
    check("e_n_rb", n_rbs, NRB);
`ifdef FSM_CFG_VERIFY_EN
    check("e_first_rb", first_rbs, 85);
    check("e_vok_at_done", 32'(vok_at_done), 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fsm_cfg_loader.md
# fsm_cfg_loader

- Configuration sequencer for the programmable-jump FSM datapath.
- Takes a parallel jump table plus clock-select and output-select bits, shifts them MSB-first into the serial configuration register, and holds the state machine in reset until loading completes.
- Optionally reads the configuration back through the serial readback path and checks it before releasing the FSM.
- Sits between the top-level pin logic and the SIPO / FSM / PISO readback chain.

## Interface
Parameters:
- N_STATES, 5, number of jump entries
- STATE_W, 5, width of one jump entry
- DIV, 1, clk cycles per serial bit (≥1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  load request, sampled only in IDLE or RUN
- cfg_state  in  N_STATES*STATE_W  jump table; entry 1 = MSBs [24:20], entry 5 = [4:0]
- cfg_clk_sel  in  1  clock-select bit to load
- cfg_out_sel  in  1  output-select bit to load
- busy  out  1  high in LOAD, SETTLE, VERIFY
- done  out  1  one-cycle pulse on entry to RUN
- fsm_hold  out  1  high keeps the FSM in reset
- ser_data  out  1  serial config bit
- ser_shift  out  1  one-cycle strobe; downstream samples ser_data on this edge
- rb_data  in  1  serial readback bit
- rb_shift  out  1  one-cycle readback strobe
- verify_ok  out  1  readback matched, sticky until next start
- verify_err  out  1  readback mismatch, sticky until next start

## Operation
- Frame: F = 2 + N_STATES*STATE_W (27 by default), sent MSB-first as {cfg_out_sel, cfg_clk_sel, cfg_state}.
- Inputs are captured into a shadow register when start is accepted. Later input changes do not affect the load in progress.
- States:
  - IDLE → LOAD on start.
  - LOAD → SETTLE after F strobes.
  - SETTLE (1 cycle) → VERIFY (macro on) or RUN.
  - VERIFY → RUN on full match; → IDLE on any mismatch.
  - RUN → LOAD on start.
- Bit pacing: a divider counts 0..DIV-1. ser_shift fires when it reaches DIV-1. ser_data holds the current bit for the whole period and advances on the cycle after the strobe.
- fsm_hold is high in every state except RUN. It reasserts in the same cycle that LOAD is entered from RUN.
- start is ignored while busy. start and rst in the same cycle: rst wins.
- rst mid-operation aborts immediately to IDLE. Shadow register and bit counters are cleared, and nothing further is shifted.
- Reset values: busy=0, done=0, fsm_hold=1, ser_data=0, ser_shift=0, rb_shift=0, verify_ok=0, verify_err=0.

## Timing
- start sampled high at edge 0 (IDLE) → busy=1 from cycle 1.
- The k-th ser_shift (k=1..F) is asserted in cycle k*DIV.
- SETTLE occupies cycle F*DIV+1.
- Without verify: done=1 and fsm_hold=0 in cycle F*DIV+2; busy=0 in the same cycle.
- With verify: rb_shift strobes follow the same divider. For R = F+5 readback bits:
  - the j-th rb_shift is in cycle F*DIV+1+j*DIV;
  - rb_data is compared on the edge where rb_shift is high;
  - done is in cycle (F+R)*DIV+2.
- Expected readback stream: {frame, 5'b01010} MSB-first.
- verify_err sets on the first mismatching bit. The block enters IDLE in the next cycle, with fsm_hold=1, busy=0, and no done.
- verify_ok sets in the same cycle as done.
- Both verify flags clear on the cycle after start is accepted.

## Configuration
- FSM_CFG_VERIFY_EN defined: the VERIFY state, rb_shift generation, the comparator, and the verify flags are built.
- Undefined: SETTLE goes directly to RUN, rb_shift, verify_ok, and verify_err are tied to 0, and rb_data is unused.

## Test plan
- Reset then idle 10 cycles → fsm_hold=1, all other outputs 0, no strobes.
- DIV=1, cfg_out_sel=1, cfg_clk_sel=0, cfg_state=25'h1555555, start pulse at cycle 0:
  - 27 strobes in cycles 1..27;
  - serial stream 1,0,1,0,1,...;
  - done in cycle 29, fsm_hold low from cycle 29.
- DIV=3, same table → strobes every 3rd cycle (3,6,...,81), ser_data stable between strobes, done in cycle 83.
- Verify enabled, rb_data mirrors the expected stream → verify_ok=1 and done in cycle 2+32+27=61. Flip readback bit 10 → verify_err=1, no done, fsm_hold stays 1, IDLE.
- start asserted during LOAD and again in RUN:
  - the LOAD-time start is ignored;
  - the RUN-time start reasserts fsm_hold the same cycle and reloads with newly captured inputs.
- rst pulsed at strobe 12 of a load → IDLE next cycle, no further strobes, fsm_hold=1, a subsequent start performs a full 27-bit load.
